// File: rtl/m_ext_pkg.sv
// Shared M-extension definitions for the iterative divider.
// Holds the divide opcode and FSM state encodings and the divider constants.
package m_ext_pkg;

  localparam int unsigned DIV_STEPS        = 32;
  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step (combinational).
// Ports: rem/quo = current partial remainder and quotient shift register,
//        divisor = unsigned divisor, rem_next/quo_next = values after the step.
module div_restore_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);

  logic [W:0] rem_sh;
  logic [W:0] trial;

  // Shift {rem, quo} left by one and try subtracting the divisor (W+1 bits wide).
  always_comb begin
    rem_sh = {rem, quo[W-1]};
    trial  = rem_sh - {1'b0, divisor};
    if (!trial[W]) begin
      rem_next = trial[W-1:0];
      quo_next = {quo[W-2:0], 1'b1};
    end else begin
      rem_next = rem_sh[W-1:0];
      quo_next = {quo[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider_iterative.sv
// Multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Ports: clk, rst (async active-low), startE/div_opcode/operand1/operand2 request,
//        kill abort, result_divide/done result handshake, busy status.
// Optional: define DIV_EARLY_OUT_EN to short-cut divide-by-zero and signed
// overflow straight from PREP to FIX (3-edge latency instead of 35).
module divider_iterative
  import m_ext_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            startE,
  input  logic [1:0]      div_opcode,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            kill,
  output logic [XLEN-1:0] result_divide,
  output logic            done,
  output logic            busy
);

  localparam int unsigned CNT_W = 5;

  div_state_e      state_q, state_d;
  div_op_e         op_q, op_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [XLEN-1:0] op2_q, op2_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] res_fix_q, res_fix_d;
  logic [XLEN-1:0] result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;
  logic            fix_ph_q, fix_ph_d;
  logic            done_d, busy_d;

  logic            is_signed, sign1, sign2;
  logic [XLEN-1:0] abs1, abs2, q_fin, r_fin;
  logic [XLEN-1:0] step_rem, step_quo;

  div_restore_step #(.W(XLEN)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (op2_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // State register plus all registered datapath and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      op_q          <= OP_DIV;
      op1_q         <= '0;
      op2_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      res_fix_q     <= '0;
      cnt_q         <= '0;
      neg_q_q       <= 1'b0;
      neg_r_q       <= 1'b0;
      fix_ph_q      <= 1'b0;
      result_divide <= '0;
      done          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      res_fix_q     <= res_fix_d;
      cnt_q         <= cnt_d;
      neg_q_q       <= neg_q_d;
      neg_r_q       <= neg_r_d;
      fix_ph_q      <= fix_ph_d;
      result_divide <= result_d;
      done          <= done_d;
      busy          <= busy_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    res_fix_d = res_fix_q;
    cnt_d     = cnt_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    fix_ph_d  = fix_ph_q;
    result_d  = result_divide;
    done_d    = 1'b0;

    is_signed = (op_q == OP_DIV) || (op_q == OP_REM);
    sign1     = is_signed && op1_q[XLEN-1];
    sign2     = is_signed && op2_q[XLEN-1];
    abs1      = sign1 ? -op1_q : op1_q;
    abs2      = sign2 ? -op2_q : op2_q;
    q_fin     = neg_q_q ? -quo_q : quo_q;
    r_fin     = neg_r_q ? -rem_q : rem_q;

    case (state_q)
      IDLE, DONE: begin
        if (startE && !kill) begin
          state_d = PREP;
          op_d    = div_op_e'(div_opcode);
          op1_d   = operand1;
          op2_d   = operand2;
        end else begin
          state_d = IDLE;
        end
      end
      PREP: begin
        rem_d    = '0;
        quo_d    = abs1;
        op2_d    = abs2;
        // A zero divisor yields all-ones regardless of sign, so never negate it.
        neg_q_d  = (sign1 ^ sign2) && (op2_q != '0);
        neg_r_d  = sign1;
        cnt_d    = '0;
        fix_ph_d = 1'b0;
        state_d  = ITER;
`ifdef DIV_EARLY_OUT_EN
        if (op2_q == '0) begin
          quo_d   = '1;
          rem_d   = op1_q;
          neg_q_d = 1'b0;
          neg_r_d = 1'b0;
          state_d = FIX;
        end else if (is_signed && (op1_q == DIV_OVF_DIVIDEND) && (op2_q == '1)) begin
          quo_d   = DIV_OVF_DIVIDEND;
          rem_d   = '0;
          neg_q_d = 1'b0;
          neg_r_d = 1'b0;
          state_d = FIX;
        end
`endif
      end
      ITER: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_W'(DIV_STEPS - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // Phase 0 applies sign correction; phase 1 publishes with done so a
        // kill during FIX leaves result_divide untouched.
        if (!fix_ph_q) begin
          res_fix_d = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? q_fin : r_fin;
          fix_ph_d  = 1'b1;
        end else begin
          result_d = res_fix_q;
          done_d   = 1'b1;
          fix_ph_d = 1'b0;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush aborts any in-flight or completing operation.
    if (kill && (state_q != IDLE)) begin
      state_d  = IDLE;
      result_d = result_divide;
      done_d   = 1'b0;
      fix_ph_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

endmodule
